// File: rtl/config_pkg.sv
// config_pkg: opcode constants, header size and parser state encoding shared by the packet parser
package config_pkg;
  localparam logic [7:0]  OP_ECHO      = 8'hEC;
  localparam logic [7:0]  OP_ADD       = 8'hAD;
  localparam logic [7:0]  OP_MUL       = 8'h88;
  localparam logic [7:0]  OP_DIV       = 8'hD1;
  localparam logic [15:0] HEADER_BYTES = 16'd4;

  typedef enum logic [2:0] {
    OPCODE,
    RSVD,
    LEN_LO,
    LEN_HI,
    ECHO,
    OPERAND,
    DRAIN
  } state_t;

  function automatic logic is_arith(input logic [7:0] op);
    return op == OP_ADD || op == OP_MUL || op == OP_DIV;
  endfunction
endpackage

// File: rtl/operand_shifter.sv
// operand_shifter: little-endian byte assembly of one operand with a full flag held until popped
module operand_shifter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_clear,
  input  logic             i_shift,
  input  logic             i_pop,
  input  logic [7:0]       i_byte,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full
);
  localparam logic [3:0] LAST = 4'(WIDTH / 8 - 1);
  logic [WIDTH-1:0] r_data;
  logic [3:0]       r_count;
  logic             r_full;
  assign o_data = r_data;
  assign o_full = r_full;
  // every byte lane is rewritten per operand, so stale lanes never leak between operands
  always_ff @(posedge clk_i)
    if (!rst_ni || i_clear) begin
      r_data  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      if (i_shift) begin
        r_data[{r_count, 3'b000} +: 8] <= i_byte;
        r_count <= r_count == LAST ? 4'd0 : r_count + 4'd1;
      end
      r_full <= (i_shift && r_count == LAST) || (r_full && !i_pop);
    end
endmodule

// File: rtl/alu_packet_parser.sv
// alu_packet_parser: splits a UART byte stream into command headers, echo bytes and ALU operands
// Optional mid-packet idle timeout is compiled in when PARSER_TIMEOUT_EN is defined
module alu_packet_parser
  import config_pkg::*;
#(
  parameter int OPERAND_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [7:0]               rx_data_i,
  input  logic                     rx_valid_i,
  output logic                     rx_ready_o,
  output logic [7:0]               opcode_o,
  output logic                     cmd_valid_o,
  output logic [7:0]               echo_data_o,
  output logic                     echo_valid_o,
  input  logic                     echo_ready_i,
  output logic [OPERAND_WIDTH-1:0] operand_o,
  output logic                     operand_valid_o,
  input  logic                     operand_ready_i,
  output logic                     operand_last_o,
  output logic                     error_o
);
  localparam logic [15:0] BYTES = 16'(OPERAND_WIDTH / 8);
  state_t      r_state;
  logic [15:0] r_rem;
  logic [7:0]  r_opcode, r_len_lo, r_echo_data;
  logic        r_echo_valid, r_cmd_valid, r_error;
  logic        w_accept, w_echo_hs, w_op_hs, w_full, w_timeout, w_short, w_arith, w_bad;
  logic [15:0] w_len, w_pay;

  assign w_accept  = rx_valid_i && rx_ready_o;
  assign w_echo_hs = r_echo_valid && echo_ready_i;
  assign w_op_hs   = w_full && operand_ready_i;
  assign w_len     = {rx_data_i, r_len_lo};
  assign w_pay     = w_len - HEADER_BYTES;
  assign w_short   = w_len < HEADER_BYTES;
  assign w_arith   = is_arith(r_opcode);
  assign w_bad     = w_short || !(w_arith || r_opcode == OP_ECHO) ||
                     (w_arith && (w_pay == 16'd0 || w_pay % BYTES != 16'd0));

  // payload states stop taking bytes once the count is spent, so the next opcode waits for the last handshake
  assign rx_ready_o = rst_ni && (r_state == ECHO    ? r_rem != 16'd0 && !(r_echo_valid && !echo_ready_i) :
                                 r_state == OPERAND ? r_rem != 16'd0 && !(w_full && !operand_ready_i) : 1'b1);

  assign opcode_o        = r_opcode;
  assign cmd_valid_o     = r_cmd_valid;
  assign echo_data_o     = r_echo_data;
  assign echo_valid_o    = r_echo_valid;
  assign operand_valid_o = w_full;
  assign operand_last_o  = w_full && r_state == OPERAND && r_rem == 16'd0;
  assign error_o         = r_error;

`ifdef PARSER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_idle;
  logic          w_idle;
  assign w_idle    = r_state != OPCODE && !w_accept && !r_echo_valid && !w_full;
  assign w_timeout = w_idle && r_idle == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk_i)
    if (!rst_ni || !w_idle || w_timeout) r_idle <= '0;
    else r_idle <= r_idle + TW'(1);
`else
  assign w_timeout = TIMEOUT_CYCLES < 0;
`endif

  operand_shifter #(.WIDTH(OPERAND_WIDTH)) u_shifter (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_clear (w_timeout),
    .i_shift (w_accept && r_state == OPERAND),
    .i_pop   (w_op_hs),
    .i_byte  (rx_data_i),
    .o_data  (operand_o),
    .o_full  (w_full)
  );

  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      r_state      <= OPCODE;
      r_rem        <= '0;
      r_opcode     <= '0;
      r_len_lo     <= '0;
      r_echo_data  <= '0;
      r_echo_valid <= 1'b0;
      r_cmd_valid  <= 1'b0;
      r_error      <= 1'b0;
    end else if (w_timeout) begin
      r_state      <= OPCODE;
      r_rem        <= '0;
      r_echo_valid <= 1'b0;
      r_cmd_valid  <= 1'b0;
      r_error      <= 1'b1;
    end else begin
      r_cmd_valid <= 1'b0;
      r_error     <= 1'b0;
      if (w_echo_hs) r_echo_valid <= 1'b0;
      if (r_state == ECHO && r_rem == 16'd0 && w_echo_hs) r_state <= OPCODE;
      if (r_state == OPERAND && r_rem == 16'd0 && w_op_hs) r_state <= OPCODE;
      if (w_accept)
        case (r_state)
          OPCODE: begin
            r_opcode <= rx_data_i;
            r_state  <= RSVD;
          end
          RSVD:   r_state <= LEN_LO;
          LEN_LO: begin
            r_len_lo <= rx_data_i;
            r_state  <= LEN_HI;
          end
          LEN_HI: begin
            r_rem       <= w_short ? 16'd0 : w_pay;
            r_cmd_valid <= !w_bad;
            r_error     <= w_bad;
            r_state     <= (w_short || w_pay == 16'd0) ? OPCODE : w_bad ? DRAIN : w_arith ? OPERAND : ECHO;
          end
          ECHO: begin
            r_echo_data  <= rx_data_i;
            r_echo_valid <= 1'b1;
            r_rem        <= r_rem - 16'd1;
          end
          OPERAND: r_rem <= r_rem - 16'd1;
          DRAIN: begin
            r_rem <= r_rem - 16'd1;
            if (r_rem == 16'd1) r_state <= OPCODE;
          end
          default: r_state <= OPCODE;
        endcase
    end
endmodule

// File: tb/tb_alu_packet_parser.sv
// tb_alu_packet_parser: directed packets with an expected-output queue checked by a decoupled monitor
module tb_alu_packet_parser;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  rx_data_i = '0;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic [7:0]  opcode_o;
  logic        cmd_valid_o;
  logic [7:0]  echo_data_o;
  logic        echo_valid_o;
  logic        echo_ready_i = 1'b1;
  logic [31:0] operand_o;
  logic        operand_valid_o;
  logic        operand_ready_i = 1'b1;
  logic        operand_last_o;
  logic        error_o;

  typedef struct {
    int          kind;
    logic [31:0] data;
    logic        last;
  } exp_t;

  localparam int K_CMD = 0, K_ERR = 1, K_ECHO = 2, K_OPND = 3;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  alu_packet_parser #(.OPERAND_WIDTH(32), .TIMEOUT_CYCLES(100)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .rx_data_i       (rx_data_i),
    .rx_valid_i      (rx_valid_i),
    .rx_ready_o      (rx_ready_o),
    .opcode_o        (opcode_o),
    .cmd_valid_o     (cmd_valid_o),
    .echo_data_o     (echo_data_o),
    .echo_valid_o    (echo_valid_o),
    .echo_ready_i    (echo_ready_i),
    .operand_o       (operand_o),
    .operand_valid_o (operand_valid_o),
    .operand_ready_i (operand_ready_i),
    .operand_last_o  (operand_last_o),
    .error_o         (error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  task automatic expect_out(input int k, input logic [31:0] d, input logic l);
    exp_t e;
    e.kind = k;
    e.data = d;
    e.last = l;
    q.push_back(e);
  endtask

  task automatic observe(input int k, input logic [31:0] d, input logic l);
    exp_t e;
    if (q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_output: got kind %0d data %h, expected no output", k, d);
      return;
    end
    e = q.pop_front();
    check("out_kind", k, e.kind);
    check("out_data", d, e.data);
    check("out_last", {31'd0, l}, {31'd0, e.last});
  endtask

  // sample just before each rising edge, when handshakes are about to complete
  always begin
    @(negedge clk_i);
    #4;
    if (cmd_valid_o) observe(K_CMD, {24'd0, opcode_o}, 1'b0);
    if (error_o) observe(K_ERR, 32'd0, 1'b0);
    if (echo_valid_o && echo_ready_i) observe(K_ECHO, {24'd0, echo_data_o}, 1'b0);
    if (operand_valid_o && operand_ready_i) observe(K_OPND, operand_o, operand_last_o);
  end

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    #1;
    while (!rx_ready_o && t < 200) begin
      @(negedge clk_i);
      #1;
      t++;
    end
    if (t >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL rx_accept_timeout: byte %h not accepted, expected acceptance within 200 cycles", b);
    end
    @(negedge clk_i);
    rx_valid_i = 1'b0;
  endtask

  task automatic hdr(input logic [7:0] op, input logic [15:0] len);
    send(op);
    send(8'h00);
    send(len[7:0]);
    send(len[15:8]);
  endtask

  task automatic echo_hi();
    expect_out(K_CMD, 32'hEC, 1'b0);
    expect_out(K_ECHO, 32'h48, 1'b0);
    expect_out(K_ECHO, 32'h69, 1'b0);
    hdr(8'hEC, 16'd6);
    send(8'h48);
    send(8'h69);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk_i);
    check("rst_rx_ready", {31'd0, rx_ready_o}, 32'd0);
    check("rst_cmd_valid", {31'd0, cmd_valid_o}, 32'd0);
    check("rst_echo_valid", {31'd0, echo_valid_o}, 32'd0);
    check("rst_operand_valid", {31'd0, operand_valid_o}, 32'd0);
    check("rst_operand_last", {31'd0, operand_last_o}, 32'd0);
    check("rst_error", {31'd0, error_o}, 32'd0);
    check("rst_opcode", {24'd0, opcode_o}, 32'd0);
    check("rst_echo_data", {24'd0, echo_data_o}, 32'd0);
    check("rst_operand", operand_o, 32'd0);
    rst_ni = 1'b1;
    #1;
    check("rx_ready_after_reset", {31'd0, rx_ready_o}, 32'd1);
    @(negedge clk_i);

    echo_hi();

    expect_out(K_CMD, 32'hAD, 1'b0);
    expect_out(K_OPND, 32'h00000001, 1'b0);
    expect_out(K_OPND, 32'h00000002, 1'b1);
    hdr(8'hAD, 16'd12);
    send(8'h01); send(8'h00); send(8'h00); send(8'h00);
    send(8'h02); send(8'h00); send(8'h00); send(8'h00);

    expect_out(K_ERR, 32'd0, 1'b0);
    hdr(8'h55, 16'd6);
    send(8'hAA);
    send(8'hBB);
    expect_out(K_CMD, 32'hEC, 1'b0);
    expect_out(K_ECHO, 32'h5A, 1'b0);
    hdr(8'hEC, 16'd5);
    send(8'h5A);

    expect_out(K_ERR, 32'd0, 1'b0);
    hdr(8'hAD, 16'd7);
    send(8'h11); send(8'h22); send(8'h33);
    expect_out(K_CMD, 32'hEC, 1'b0);
    hdr(8'hEC, 16'd4);

    expect_out(K_ERR, 32'd0, 1'b0);
    hdr(8'hEC, 16'd2);
    expect_out(K_ERR, 32'd0, 1'b0);
    hdr(8'hD1, 16'd4);

    operand_ready_i = 1'b0;
    expect_out(K_CMD, 32'h88, 1'b0);
    expect_out(K_OPND, 32'h12345678, 1'b1);
    hdr(8'h88, 16'd8);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    repeat (5) @(negedge clk_i);
    check("mul_held_valid", {31'd0, operand_valid_o}, 32'd1);
    check("mul_held_data", operand_o, 32'h12345678);
    check("mul_held_last", {31'd0, operand_last_o}, 32'd1);
    operand_ready_i = 1'b1;
    @(negedge clk_i);

    expect_out(K_CMD, 32'hEC, 1'b0);
    expect_out(K_ECHO, 32'h48, 1'b0);
    expect_out(K_ECHO, 32'h69, 1'b0);
    hdr(8'hEC, 16'd6);
    echo_ready_i = 1'b0;
    send(8'h48);
    rx_data_i  = 8'h69;
    rx_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp_rx_ready_low", {31'd0, rx_ready_o}, 32'd0);
      check("bp_echo_held", {24'd0, echo_data_o}, 32'h48);
      @(negedge clk_i);
    end
    echo_ready_i = 1'b1;
    send(8'h69);

    send(8'hEC);
    send(8'h00);
    send(8'h06);
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    check("midrst_rx_ready", {31'd0, rx_ready_o}, 32'd0);
    check("midrst_opcode", {24'd0, opcode_o}, 32'd0);
    rst_ni = 1'b1;
    #1;
    check("midrst_rx_ready_release", {31'd0, rx_ready_o}, 32'd1);
    @(negedge clk_i);
    echo_hi();

`ifdef PARSER_TIMEOUT_EN
    begin
      int n;
      expect_out(K_ERR, 32'd0, 1'b0);
      send(8'hAD);
      send(8'h00);
      n = 0;
      for (int i = 1; i <= 300; i++) begin
        @(posedge clk_i);
        #1;
        if (error_o) begin
          n = i;
          break;
        end
      end
      check("timeout_cycle", n, 32'd100);
      @(negedge clk_i);
      echo_hi();
    end
`endif

    repeat (20) @(negedge clk_i);
    check("queue_empty", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_packet_parser.md
ALU_PACKET_PARSER -- requirements
Module: alu_packet_parser

Interface
REQ-001 SHALL have parameter OPERAND_WIDTH, default 32, operand width in bits; multiple of 8, 8..64.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, idle cycles mid-packet before abort.
REQ-003 SHALL have ports:
 clk_i  input  1  single clock, all logic rising-edge.
 rst_ni  input  1  reset, synchronous, active-low.
 rx_data_i  input  8  byte from UART receiver.
 rx_valid_i  input  1  rx_data_i valid.
 rx_ready_o  output  1  parser accepts byte this cycle.
 opcode_o  output  8  opcode of current packet, held until next header.
 cmd_valid_o  output  1  one-cycle pulse when a legal header completes.
 echo_data_o  output  8  echo payload byte.
 echo_valid_o / echo_ready_i  output / input  1  echo stream handshake.
 operand_o  output  OPERAND_WIDTH  assembled operand.
 operand_valid_o / operand_ready_i  output / input  1  operand stream handshake.
 operand_last_o  output  1  marks final operand of packet.
 error_o  output  1  one-cycle pulse on format error or timeout.

Function
REQ-004 SHALL transfer a byte when rx_valid_i && rx_ready_o; same rule on both output streams.
REQ-005 SHALL parse packet: opcode, reserved (ignored), length LSB, length MSB, payload; length counts all bytes including the 4 header bytes.
REQ-006 SHALL use FSM states OPCODE, RSVD, LEN_LO, LEN_HI, ECHO, OPERAND, DRAIN; OPCODE->RSVD->LEN_LO->LEN_HI each on one accepted byte.
REQ-007 SHALL, on accepting LEN_HI, evaluate header in same cycle: legal -> cmd_valid_o pulse next cycle, enter ECHO (echo opcode) or OPERAND (arith opcode); length==4 legal for echo -> return to OPCODE with no payload.
REQ-008 SHALL flag illegal: unknown opcode; length<4; arith opcode with (length-4)==0 or not a multiple of OPERAND_WIDTH/8 -> error_o pulse, enter DRAIN, discard (length-4) bytes, no output valid asserted; length<4 -> straight to OPCODE.
REQ-009 SHALL in ECHO present each payload byte on echo_data_o one cycle after acceptance; rx_ready_o low while echo_valid_o && !echo_ready_i.
REQ-010 SHALL in OPERAND assemble bytes little-endian (first byte to bits [7:0]); operand_valid_o asserts the cycle after the last byte of an operand; rx_ready_o low while operand_valid_o && !operand_ready_i.
REQ-011 SHALL assert operand_last_o with the final operand of the packet only.
REQ-012 SHALL track remaining payload in a 16-bit down-counter; reaching zero returns to OPCODE after the final output handshake (or final drained byte).
REQ-013 SHALL accept a new opcode byte in the cycle following the final payload handshake (no dead cycles between packets).

Reset
REQ-014 SHALL, while rst_ni low at clk_i edge, enter OPCODE, clear counters, drive rx_ready_o=0, cmd_valid_o=0, echo_valid_o=0, operand_valid_o=0, operand_last_o=0, error_o=0, opcode_o=0, data outputs 0.
REQ-015 SHALL discard any partial packet on reset mid-operation; rx_ready_o=1 first cycle after reset release.

Configuration
REQ-016 SHALL compile timeout logic only when PARSER_TIMEOUT_EN is defined: in any state but OPCODE, TIMEOUT_CYCLES consecutive cycles with no accepted rx byte and no pending output -> error_o pulse, outputs invalidated, return to OPCODE.
REQ-017 SHALL, without PARSER_TIMEOUT_EN, have no timeout counter; parser waits indefinitely.

Structure
REQ-018 SHALL place opcode constants (OP_ECHO=8'hEC, OP_ADD=8'hAD, OP_MUL=8'h88, OP_DIV=8'hD1), HEADER_BYTES=4 and the FSM state enum in config_pkg.
REQ-019 SHALL factor operand assembly into sub-module operand_shifter (byte shift-in, byte count, full flag).

Verification
REQ-020 SHALL cover echo: bytes EC 00 06 00 48 69 -> cmd_valid_o once, opcode_o=EC, echo bytes 48 then 69, no error.
REQ-021 SHALL cover add: AD 00 0C 00 01 00 00 00 02 00 00 00 -> operands 0x00000001 then 0x00000002 with operand_last_o on second.
REQ-022 SHALL cover bad opcode: 55 00 06 00 AA BB -> error_o one pulse, both bytes drained, no output valids, next echo packet parsed correctly.
REQ-023 SHALL cover misaligned length: AD 00 07 00 + 3 bytes -> error_o, DRAIN consumes 3 bytes.
REQ-024 SHALL cover backpressure: echo_ready_i low 10 cycles during "Hi" -> rx_ready_o low, byte 69 held, order preserved.
REQ-025 SHALL cover reset after LEN_LO and (PARSER_TIMEOUT_EN, TIMEOUT_CYCLES=100) stall after RSVD -> error_o at cycle 100, next packet parsed normally.
